// File: rtl/aes_sbox_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine over LANES bytes with valid/ready handshakes.
// Byte k occupies bits [8k:8k+7] of the data words; bit 8k is the byte MSB.
module aes_sbox_pipe #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [0:8*LANES-1]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inv,
    output logic [0:8*LANES-1]   out_data,
    output logic                 busy
);

    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
        return inv ? SBOX_INV[x] : SBOX_FWD[x];
    endfunction

    function automatic logic [0:8*LANES-1] sub_word(input logic [0:8*LANES-1] d,
                                                    input logic             inv);
        logic [0:8*LANES-1] w_res;
        w_res = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_res[8*k +: 8] = sub_byte(d[8*k +: 8], inv);
        end
        return w_res;
    endfunction

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("aes_sbox_pipe: LANES must be in 1..16");
    end

    if (PIPE_STAGES == 2) begin : g_two
        logic               r_v0;
        logic               r_inv0;
        logic [0:8*LANES-1] r_data0;
        logic               r_v1;
        logic               r_inv1;
        logic [0:8*LANES-1] r_data1;
        logic               w_ld0;
        logic               w_ld1;

        // Load enables chain back from the output so a full pipe still moves every cycle.
        assign w_ld1 = !r_v1 || out_ready;
        assign w_ld0 = !r_v0 || w_ld1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v0    <= 1'b0;
                r_inv0  <= 1'b0;
                r_data0 <= '0;
                r_v1    <= 1'b0;
                r_inv1  <= 1'b0;
                r_data1 <= '0;
            end else begin
                if (w_ld0) begin
                    r_v0 <= in_valid;
                    if (in_valid) begin
                        r_inv0  <= in_inv;
                        r_data0 <= in_data;
                    end
                end
                if (w_ld1) begin
                    r_v1 <= r_v0;
                    if (r_v0) begin
                        r_inv1  <= r_inv0;
                        r_data1 <= sub_word(r_data0, r_inv0);
                    end
                end
            end
        end

        assign in_ready  = w_ld0;
        assign out_valid = r_v1;
        assign out_inv   = r_inv1;
        assign out_data  = r_data1;
        assign busy      = r_v0 || r_v1;
    end else if (PIPE_STAGES == 1) begin : g_one
        logic               r_v0;
        logic               r_inv0;
        logic [0:8*LANES-1] r_data0;
        logic               w_ld0;

        assign w_ld0 = !r_v0 || out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v0    <= 1'b0;
                r_inv0  <= 1'b0;
                r_data0 <= '0;
            end else if (w_ld0) begin
                r_v0 <= in_valid;
                if (in_valid) begin
                    r_inv0  <= in_inv;
                    r_data0 <= sub_word(in_data, in_inv);
                end
            end
        end

        assign in_ready  = w_ld0;
        assign out_valid = r_v0;
        assign out_inv   = r_inv0;
        assign out_data  = r_data0;
        assign busy      = r_v0;
    end else begin : g_bad_stages
        $error("aes_sbox_pipe: PIPE_STAGES must be 1 or 2");
    end

endmodule
